// File: rtl/decode_pkg.sv
// Shared decode types: RV base opcodes, instruction format codes, control fields of a decoded bundle.
// Width-dependent parts (pc/imm/register addresses) are added by the stage that knows XLEN/RA_W.
package decode_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } fmt_e;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] func3;
      logic [6:0] func7;
      fmt_e       fmt;
      logic       rd_we;
      logic       rs1_used;
      logic       rs2_used;
      logic       illegal;
   } dec_ctrl_t;

   function automatic fmt_e fmt_of_opcode(input logic [6:0] opc);
      fmt_e f;
      case (opc)
         OPC_OP:                                      f = FMT_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:  f = FMT_I;
         OPC_STORE:                                   f = FMT_S;
         OPC_BRANCH:                                  f = FMT_B;
         OPC_LUI, OPC_AUIPC:                          f = FMT_U;
         OPC_JAL:                                     f = FMT_J;
         default:                                     f = FMT_ILL;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Upstream instruction handshake and downstream decoded-bundle handshake of the decode stage.
// master = the side driving instructions and out_ready/flush; slave = the decode stage itself.
interface decode_stage_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   import decode_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            flush;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      opcode;
   logic [2:0]      func3;
   logic [6:0]      func7;
   logic [RA_W-1:0] rd;
   logic [RA_W-1:0] rs1;
   logic [RA_W-1:0] rs2;
   logic            rd_we;
   logic            rs1_used;
   logic            rs2_used;
   logic [XLEN-1:0] imm;
   fmt_e            fmt;
   logic            illegal;

   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, opcode, func3, func7, rd, rs1, rs2,
             rd_we, rs1_used, rs2_used, imm, fmt, illegal
   );

   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, opcode, func3, func7, rd, rs1, rs2,
             rd_we, rs1_used, rs2_used, imm, fmt, illegal
   );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV immediate extraction: builds the 32-bit immediate for the given format,
// then sign-extends it to XLEN. R and ILL formats yield zero.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_i,
   input  fmt_e            fmt_i,
   output logic [XLEN-1:0] imm_o
);

   logic signed [31:0] imm32;
   logic               unused_opc;

   assign unused_opc = ^inst_i[6:0];

   always_comb begin
      imm32 = '0;
      case (fmt_i)
         FMT_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
         FMT_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         FMT_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                           inst_i[11:8], 1'b0};
         FMT_U:   imm32 = {inst_i[31:12], 12'b0};
         FMT_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                           inst_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Size cast of a signed operand sign-extends for XLEN=64.
   assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Single-cycle RV instruction decode with a 2-entry (output + skid) register pair.
// in_ready is the registered inverse of skid occupancy; flush and rst drop everything held.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave dec_if
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rd;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      dec_ctrl_t       ctrl;
   } bundle_t;

   bundle_t         out_q, out_d, skid_q, skid_d, new_b;
   logic            out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
   logic            in_fire;
   fmt_e            fmt_raw, fmt_dec;
   logic            rd_use, rs1_use, rs2_use, ra_ovf, ill;
   logic [XLEN-1:0] imm_w;
   logic [31:0]     inst;

   assign inst    = dec_if.in_inst;
   assign in_fire = dec_if.in_valid & ~skid_vld_q;

   always_comb begin
      fmt_raw = fmt_of_opcode(inst[6:0]);
      rs1_use = fmt_raw inside {FMT_R, FMT_I, FMT_S, FMT_B};
      rs2_use = fmt_raw inside {FMT_R, FMT_S, FMT_B};
      rd_use  = fmt_raw inside {FMT_R, FMT_I, FMT_U, FMT_J};
      // A narrow register file cannot address x16..x31.
      ra_ovf  = (RA_W < 5) && ((rd_use & inst[11]) | (rs1_use & inst[19]) | (rs2_use & inst[24]));
      fmt_dec = ra_ovf ? FMT_ILL : fmt_raw;
      ill     = (fmt_dec == FMT_ILL);
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst_i (inst),
      .fmt_i  (fmt_dec),
      .imm_o  (imm_w)
   );

   always_comb begin
      new_b               = '0;
      new_b.pc            = dec_if.in_pc;
      new_b.imm           = imm_w;
      new_b.ctrl.opcode   = inst[6:0];
      new_b.ctrl.func3    = inst[14:12];
      new_b.ctrl.func7    = inst[31:25];
      new_b.ctrl.fmt      = fmt_dec;
      new_b.ctrl.illegal  = ill;
      new_b.ctrl.rd_we    = rd_use & ~ill;
      new_b.ctrl.rs1_used = rs1_use & ~ill;
      new_b.ctrl.rs2_used = rs2_use & ~ill;
      new_b.rd            = (rd_use & ~ill)  ? RA_W'(inst[11:7])  : '0;
      new_b.rs1           = (rs1_use & ~ill) ? RA_W'(inst[19:15]) : '0;
      new_b.rs2           = (rs2_use & ~ill) ? RA_W'(inst[24:20]) : '0;
   end

   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (dec_if.flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!out_vld_q || dec_if.out_ready) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            out_vld_d = in_fire;
            if (in_fire) out_d = new_b;
         end
      end else if (in_fire) begin
         skid_d     = new_b;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign dec_if.in_ready  = ~skid_vld_q;
   assign dec_if.out_valid = out_vld_q;
   assign dec_if.out_pc    = out_q.pc;
   assign dec_if.opcode    = out_q.ctrl.opcode;
   assign dec_if.func3     = out_q.ctrl.func3;
   assign dec_if.func7     = out_q.ctrl.func7;
   assign dec_if.rd        = out_q.rd;
   assign dec_if.rs1       = out_q.rs1;
   assign dec_if.rs2       = out_q.rs2;
   assign dec_if.rd_we     = out_q.ctrl.rd_we;
   assign dec_if.rs1_used  = out_q.ctrl.rs1_used;
   assign dec_if.rs2_used  = out_q.ctrl.rs2_used;
   assign dec_if.imm       = out_q.imm;
   assign dec_if.fmt       = out_q.ctrl.fmt;
   assign dec_if.illegal   = out_q.ctrl.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath/PC/immediate width; legal values 32, 64.
REQ-002 Parameter RA_W, 5, register-address width; legal values 4 (RV32E), 5.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream instruction present.
REQ-006 in_ready  out  1  stage can accept; transfer when in_valid & in_ready.
REQ-007 in_inst  in  32  raw instruction word.
REQ-008 in_pc  in  XLEN  PC of in_inst.
REQ-009 flush  in  1  discard all held instructions (branch redirect).
REQ-010 out_valid  out  1  decoded bundle present.
REQ-011 out_ready  in  1  downstream accepts; transfer when out_valid & out_ready.
REQ-012 out_pc  out  XLEN  PC of decoded bundle.
REQ-013 opcode/func3/func7  out  7/3/7  inst[6:0], inst[14:12], inst[31:25].
REQ-014 rd/rs1/rs2  out  RA_W each  register addresses, zero when unused.
REQ-015 rd_we/rs1_used/rs2_used  out  1 each  field-valid flags.
REQ-016 imm  out  XLEN  sign-extended immediate, zero for R-type.
REQ-017 fmt  out  3  format code R/I/S/B/U/J/ILL.
REQ-018 illegal  out  1  opcode not in supported set.

Function
REQ-019 Decoding: R=0110011; I=0010011,0000011,1100111,1110011; S=0100011; B=1100011; U=0110111,0010111; J=1101111; anything else ILL.
REQ-020 rs1 from inst[19:15] for R/I/S/B; rs2 from inst[24:20] for R/S/B; rd from inst[11:7] for R/I/U/J; otherwise field and flag 0.
REQ-021 Register fields are truncated to RA_W bits; RA_W=4 with field bit 4 set asserts illegal.
REQ-022 Immediates per RISC-V base encoding, sign bit inst[31], extended to XLEN; B/J bit 0 = 0; U low 12 bits = 0.
REQ-023 ILL bundles: illegal=1, all register fields, flags and imm = 0; bundle still delivered in order.
REQ-024 Latency: accepted instruction appears on out_* exactly one cycle later when output slot empty or draining.
REQ-025 Storage: output register plus one skid register (2 entries); in_ready is registered and equals !skid_valid.
REQ-026 out_valid & !out_ready while new transfer accepted: new bundle goes to skid; next cycle in_ready=0.
REQ-027 Output drains: skid moves to output register same edge; in_ready returns to 1 next cycle.
REQ-028 Output bundle stays stable while out_valid & !out_ready.
REQ-029 Order strictly FIFO; no bundle dropped or duplicated except by flush.
REQ-030 flush: next edge clears out_valid and skid_valid; in_valid on the flush cycle is discarded; in_ready=1 next cycle.
REQ-031 flush and out_ready in the same cycle: no output transfer counted by downstream (flush wins).

Reset
REQ-032 During rst: out_valid=0, skid empty, in_ready=1, all decoded outputs and out_pc = 0.
REQ-033 rst asserted mid-transfer discards all held bundles; first accept on first edge after deassertion.

Structure
REQ-034 Package decode_pkg holds opcode constants, fmt_e enum (R,I,S,B,U,J,ILL) and decoded-bundle struct parameterised by XLEN/RA_W via typedef.
REQ-035 One combinational sub-module imm_gen (inst, fmt -> imm); field decode inline; decode_stage holds both registers.
REQ-036 No latches: every combinational output assigned on every path.

Verification
REQ-037 add x3,x1,x2 0x002081B3, out_ready=1 -> next cycle fmt=R, rd=3, rs1=1, rs2=2, all flags 1, imm=0.
REQ-038 sw x5,8(x2) 0x00512423 -> fmt=S, rs1=2, rs2=5, rd=0, rd_we=0, imm=0x00000008.
REQ-039 beq x0,x0,-4 0xFE000EE3 -> fmt=B, imm=0xFFFFFFFC; lui x1,0x12345 0x123450B7 -> fmt=U, imm=0x12345000, rs1_used=0.
REQ-040 Back-to-back 3 instructions, out_ready=0 for 2 cycles -> in_ready=0 after 2nd accept, 3rd held upstream, outputs delivered in order once out_ready=1.
REQ-041 Skid full then flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and flush-cycle instructions never appear.
REQ-042 Word 0x0000007F and RA_W=4 with rd=16 -> illegal=1, fmt=ILL, fields 0; rst mid-stall -> out_valid=0 immediately.
